// File: rtl/dmem_responder.sv
// Data-memory responder: services execute-stage load/store requests against a 64-bit RAM with
// programmable wait states. Defining DMEM_WRITE_BUFFER_EN adds a one-entry posted-write buffer.
module dmem_responder #(
   parameter int unsigned DEPTH_LOG2  = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] req_addr,
   input  logic [7:0]  req_be,
   input  logic        req_wen,
   input  logic [63:0] req_wdata,
   output logic        busy,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err
);

   localparam int unsigned Words    = 1 << DEPTH_LOG2;
   localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
   localparam bit          ZeroWait = (WAIT_CYCLES == 0);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

   state_e state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   logic [DEPTH_LOG2-1:0] idx_q;
   logic [7:0]            be_q;
   logic                  wen_q;
   logic [63:0]           wdata_q;
   logic                  inrange_q;
   logic [63:0]           rdata_q;
   logic                  err_q;

   logic [63:0] mem [Words];

   logic                  req_present;
   logic [28:0]           req_off;
   logic                  req_inrange;
   logic [DEPTH_LOG2-1:0] req_idx;
   logic                  unused_addr_lsb;

   logic accept;
   logic fsm_access;

   // Posted-write buffer hooks; tied off when the buffer is not built.
   logic                  post;
   logic                  hold;
   logic                  drain;
   logic [DEPTH_LOG2-1:0] wb_idx;
   logic [7:0]            wb_be;
   logic [63:0]           wb_data;
   logic                  wb_inrange;

   logic [DEPTH_LOG2-1:0] acc_idx;
   logic [7:0]            acc_be;
   logic                  acc_wen;
   logic [63:0]           acc_wdata;
   logic                  acc_inrange;
   logic                  wr_en;
   logic                  rd_en;

   assign req_present     = |req_be;
   assign unused_addr_lsb = ^req_addr[2:0];

   // Offset in doublewords; addresses below the base wrap to large values and fail the check.
   assign req_off     = req_addr[31:3] - BASE_ADDR[31:3];
   assign req_inrange = (req_off >> DEPTH_LOG2) == '0;
   assign req_idx     = req_off[DEPTH_LOG2-1:0];

`ifdef DMEM_WRITE_BUFFER_EN
   logic       wb_valid_q;
   logic [4:0] wb_cnt_q;

   assign post  = (state_q == StIdle) && req_present && req_wen && !wb_valid_q;
   assign hold  = wb_valid_q;
   assign drain = wb_valid_q && (wb_cnt_q == 5'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         wb_valid_q <= 1'b0;
         wb_cnt_q   <= '0;
      end else if (post) begin
         wb_valid_q <= 1'b1;
         wb_cnt_q   <= 5'(WAIT_CYCLES) + 5'd1;
      end else if (wb_valid_q) begin
         wb_cnt_q <= wb_cnt_q - 5'd1;
         if (wb_cnt_q == 5'd1) wb_valid_q <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (post) begin
         wb_idx     <= req_idx;
         wb_be      <= req_be;
         wb_data    <= req_wdata;
         wb_inrange <= req_inrange;
      end
   end
`else
   assign post       = 1'b0;
   assign hold       = 1'b0;
   assign drain      = 1'b0;
   assign wb_idx     = '0;
   assign wb_be      = '0;
   assign wb_data    = '0;
   assign wb_inrange = 1'b0;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      accept     = 1'b0;
      fsm_access = 1'b0;
      case (state_q)
         StIdle: begin
            if (req_present && !hold) begin
               accept = 1'b1;
               if (post) begin
                  state_d = StResp;
               end else if (ZeroWait) begin
                  fsm_access = 1'b1;
                  state_d    = StResp;
               end else begin
                  cnt_d   = WaitInit;
                  state_d = StWait;
               end
            end
         end
         StWait: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
               fsm_access = 1'b1;
               state_d    = StResp;
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         idx_q     <= req_idx;
         be_q      <= req_be;
         wen_q     <= req_wen;
         wdata_q   <= req_wdata;
         inrange_q <= req_inrange;
      end
   end

   // Zero-wait accesses happen in the accept cycle straight from the request inputs.
   always_comb begin
      acc_idx     = idx_q;
      acc_be      = be_q;
      acc_wen     = wen_q;
      acc_wdata   = wdata_q;
      acc_inrange = inrange_q;
      if (drain) begin
         acc_idx     = wb_idx;
         acc_be      = wb_be;
         acc_wen     = 1'b1;
         acc_wdata   = wb_data;
         acc_inrange = wb_inrange;
      end else if (state_q == StIdle) begin
         acc_idx     = req_idx;
         acc_be      = req_be;
         acc_wen     = req_wen;
         acc_wdata   = req_wdata;
         acc_inrange = req_inrange;
      end
   end

   assign wr_en = (fsm_access || drain) && acc_wen && acc_inrange && !rst;
   assign rd_en = fsm_access && !acc_wen && acc_inrange && !rst;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int i = 0; i < 8; i++) begin
            if (acc_be[i]) mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            rdata_q <= '0;
            err_q   <= !req_inrange;
         end
         if (rd_en) rdata_q <= mem[acc_idx];
      end
   end

   assign busy       = ((state_q == StIdle) && req_present && !post) || (state_q == StWait);
   assign resp_valid = (state_q == StResp);
   assign resp_rdata = resp_valid ? rdata_q : '0;
   assign resp_err   = resp_valid && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (default build): random loads/stores against a word-array
// model, with busy-length, response-cycle, range-error and reset-abandon checks.
module tb_dmem_responder;

   localparam int unsigned DL   = 12;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int unsigned W    = 2;
   localparam longint      SPAN = 8 * (longint'(1) << DL);

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] req_addr = '0;
   logic [7:0]  req_be = '0;
   logic        req_wen = 1'b0;
   logic [63:0] req_wdata = '0;
   logic        busy;
   logic        resp_valid;
   logic [63:0] resp_rdata;
   logic        resp_err;

   dmem_responder #(
      .DEPTH_LOG2 (DL),
      .BASE_ADDR  (BASE),
      .WAIT_CYCLES(W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wen   (req_wen),
      .req_wdata (req_wdata),
      .busy      (busy),
      .resp_valid(resp_valid),
      .resp_rdata(resp_rdata),
      .resp_err  (resp_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [63:0] rd;
      logic        err;
      int          at;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   logic [63:0] model[longint];
   int          compared = 0;
   int          mismatched = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      compared++;
      if (got !== want) begin
         mismatched++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      longint al = longint'(a) & ~longint'(7);
      return al >= longint'(BASE) && al < longint'(BASE) + SPAN;
   endfunction

   function automatic longint word_of(input logic [31:0] a);
      return ((longint'(a) & ~longint'(7)) - longint'(BASE)) >>> 3;
   endfunction

   // Monitor: every response must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (resp_valid === 1'b1) begin
         if (sb.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_resp: got resp_valid=1, expected none (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("resp_rdata", resp_rdata, mon_e.rd);
            check("resp_err", 64'(resp_err), 64'(mon_e.err));
            check("resp_cycle", 64'(cyc), 64'(mon_e.at));
         end
      end
   end

   // One full transaction; called #1 after a rising edge, leaves the request removed.
   task automatic issue(input logic [31:0] a, input logic [7:0] be, input logic wen,
                        input logic [63:0] wd);
      exp_t        e;
      logic [63:0] w;
      int          n;
      e.rd  = '0;
      e.err = !in_range(a);
      e.at  = cyc + W + 1;
      if (in_range(a)) begin
         if (wen) begin
            w = model.exists(word_of(a)) ? model[word_of(a)] : '0;
            for (int i = 0; i < 8; i++) if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
            model[word_of(a)] = w;
         end else begin
            e.rd = model[word_of(a)];
         end
      end
      sb.push_back(e);
      req_addr  = a;
      req_be    = be;
      req_wen   = wen;
      req_wdata = wd;
      n = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         n++;
      end
      check("busy_cycles", 64'(n), 64'(W + 1));
      @(posedge clk);
      #1;
      req_be = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Start a store, then reset while it waits; nothing may be written or answered.
   task automatic abandon(input logic [31:0] a, input int wait_n);
      req_addr  = a;
      req_be    = 8'hFF;
      req_wen   = 1'b1;
      req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
      idle(wait_n);
      rst    = 1'b1;
      req_be = '0;
      idle(1);
      rst = 1'b0;
      idle(1);
   endtask

   logic [31:0] pool[12];
   logic [31:0] a;
   logic        wen;

   initial begin
      idle(3);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("idle_busy", 64'(busy), 64'd0);
         check("idle_valid", 64'(resp_valid), 64'd0);
         check("idle_rdata", resp_rdata, 64'd0);
         check("idle_err", 64'(resp_err), 64'd0);
      end
      @(posedge clk);
      #1;

      issue(32'h8000_0010, 8'hFF, 1'b1, 64'h1122_3344_5566_7788);
      issue(32'h8000_0010, 8'hFF, 1'b0, '0);
      issue(32'h8000_0010, 8'h0C, 1'b1, 64'h0000_0000_AABB_0000);
      issue(32'h8000_0013, 8'hFF, 1'b0, '0);

      // Words aliased by the low index bits of out-of-range addresses must stay untouched.
      issue(32'h8000_7FF8, 8'hFF, 1'b1, 64'hCAFE_0000_0000_7FF8);
      issue(32'h8000_0000, 8'hFF, 1'b1, 64'hCAFE_0000_0000_0000);
      issue(32'h7FFF_FFF8, 8'hFF, 1'b0, '0);
      issue(32'h8000_8000, 8'hFF, 1'b0, '0);
      issue(32'h7FFF_FFF8, 8'hFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(32'h8000_8000, 8'hFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
      issue(32'h8000_7FF8, 8'hFF, 1'b0, '0);
      issue(32'h8000_0000, 8'hFF, 1'b0, '0);

      abandon(32'h8000_0010, 1);
      issue(32'h8000_0010, 8'hFF, 1'b0, '0);
      abandon(32'h8000_0010, 2);
      issue(32'h8000_0010, 8'hFF, 1'b0, '0);

      pool[0] = 32'h8000_0000;
      pool[1] = 32'h8000_7FF8;
      pool[2] = 32'h8000_0010;
      for (int i = 3; i < 12; i++) pool[i] = BASE + 32'(8 * $urandom_range(0, 4095));
      for (int i = 0; i < 12; i++) issue(pool[i], 8'hFF, 1'b1, {$urandom, $urandom});

      for (int i = 0; i < 120; i++) begin
         wen = 1'($urandom);
         case ($urandom_range(0, 9))
            0:       a = $urandom & 32'h7FFF_FFFF;
            1:       a = 32'h8000_8000 + ($urandom & 32'h7FFF_7FFF);
            default: a = pool[$urandom_range(0, 11)] | 32'($urandom_range(0, 7));
         endcase
         issue(a, 8'($urandom_range(1, 255)), wen, {$urandom, $urandom});
         idle($urandom_range(0, 2));
      end

      for (int k = 0; k < 50 && sb.size() != 0; k++) idle(1);
      check("pending_responses", 64'(sb.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far end of the execute stage's external-RAM port. Accepts the doubleword-aligned address, byte-enable, write-enable and store data that execute drives, and services them against an internal single-ported 64-bit-wide RAM with a programmable number of wait states. Returns the raw 64-bit read word and an error flag. Drives `busy` into the pipeline's global stall (`stop_all`) so execute holds its request until it has been serviced.

## Interface
- `DEPTH_LOG2`, default 12: RAM depth is 2^DEPTH_LOG2 doublewords.
- `BASE_ADDR`, default 32'h8000_0000: byte address of RAM word 0; must be 8-byte aligned.
- `WAIT_CYCLES`, default 2: wait states inserted between request acceptance and response, range 0..15.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_addr` in 32: byte address; bits [2:0] are ignored (treated as zero).
- `req_be` in 8: byte enables, active-high, bit i selects byte lane i. A request is present iff `req_be != 0`.
- `req_wen` in 1: 1 = store, 0 = load; qualified by `req_be != 0`.
- `req_wdata` in 64: store data, lane-aligned; only enabled lanes are written.
- `busy` out 1: stall request to the pipeline; combinational.
- `resp_valid` out 1: one-cycle pulse marking completion of the accepted request.
- `resp_rdata` out 64: full RAM word for loads, valid while `resp_valid`=1; zero for stores and errors.
- `resp_err` out 1: the completing request fell outside the RAM window; valid while `resp_valid`=1.

## Operation
- Word index = `(req_addr - BASE_ADDR) >> 3`. In range iff `req_addr[31:3]` lies within `[BASE_ADDR, BASE_ADDR + 8*2^DEPTH_LOG2)`, compared at doubleword granularity.
- FSM states: IDLE, WAIT, RESP.
  - IDLE with a request present: latch addr/be/wen/wdata and the in-range flag. Load the wait counter with WAIT_CYCLES. Go to WAIT, or go directly to RESP when WAIT_CYCLES=0.
  - WAIT: decrement the counter. On the cycle the counter reads 1, perform the RAM access (read the word, or byte-merge write the enabled lanes) and go to RESP.
  - RESP: assert `resp_valid` and drive `resp_rdata`/`resp_err` from registers. Return to IDLE. A new request is not accepted in the RESP cycle.
  - IDLE with no request: stay.
- `busy` = (IDLE and request present) or WAIT. `busy` is 0 in RESP, so the pipeline advances at the end of the RESP cycle.
- Out-of-range store: no RAM write; `resp_err`=1. Out-of-range load: `resp_rdata`=0; `resp_err`=1.
- A request still held in the cycle after RESP (pipeline stalled by another source) is re-serviced as a new request. Reloads and identical re-stores are idempotent, so this is permitted.
- RAM contents are not reset.

## Timing
- Reset: state=IDLE, counter=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0. `busy` reflects the request inputs combinationally, and is 0 when `req_be`=0.
- A request first present in cycle T produces `resp_valid` in cycle T+WAIT_CYCLES+1.
- `busy` is high in cycles T..T+WAIT_CYCLES.
- `rst` asserted during WAIT: the transaction is abandoned, with no write and no response. A store whose RAM write already occurred stays committed.
- The upstream must hold all `req_*` stable while `busy`=1. Changes during that window are ignored after latching.

## Configuration
- `DMEM_WRITE_BUFFER_EN` defined: adds a one-entry posted-write buffer.
  - A store seen in IDLE while the buffer is empty is captured into the buffer in that cycle, with `busy`=0. `resp_valid` pulses in T+1 with `resp_err` from the range check.
  - The buffer drains to RAM after WAIT_CYCLES+1 cycles in the background.
  - Any request arriving while the buffer is occupied sees `busy`=1 until the buffer is empty, then proceeds normally.
  - Reset empties the buffer without writing.
- `DMEM_WRITE_BUFFER_EN` undefined: stores follow the IDLE/WAIT/RESP path exactly like loads.

## Test plan
- Reset, then `req_be`=0 for 10 cycles -> `busy`=0, `resp_valid`=0, all outputs 0.
- WAIT_CYCLES=2: store addr 0x8000_0010, be=0xFF, wdata=0x1122334455667788, then load from the same address -> store `busy` high 3 cycles and `resp_valid` at T+3; load returns 0x1122334455667788.
- Store addr 0x8000_0010 be=0x0C wdata=0x00000000AABB0000 over the word above, then load -> 0x11223344AABB7788.
- Load addr 0x7FFF_FFF8 and load at BASE_ADDR+8*2^DEPTH_LOG2 -> `resp_err`=1, `resp_rdata`=0. Store to 0x7FFF_FFF8 leaves RAM unchanged.
- WAIT_CYCLES=0: back-to-back loads -> each `busy` high 1 cycle, `resp_valid` at T+1, one idle RESP cycle between acceptances.
- `DMEM_WRITE_BUFFER_EN`: store then immediate load to the same word -> store `busy`=0; load `busy` high until drain plus its own latency; returns the stored data. Also assert `rst` mid-drain -> RAM unchanged.
